dmem_responder: RTL and testbench

- Data-memory target for the core's valid/yumi data-memory interface.
- Accepts one load or store request at a time and acknowledges it with a one-cycle yumi.
- Waits a programmable latency, then presents a response (valid plus read_data) held until the core's yumi.
- Sits between a core's to_mem_o/data_mem_addr and its from_mem_i; serves as the lab data memory and as the bench memory model.

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target for a valid/yumi core interface.
// Requests are acknowledged with a one-cycle yumi; the response follows after a programmable latency.

package dmem_responder_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

endpackage

// State table
//   IDLE | ready; a valid request at the edge is accepted and committed/read
//   ACK  | one-cycle request acknowledge (from_mem_o.yumi)
//   WAIT | latency countdown
//   RESP | response presented, held until the core's yumi
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     to_mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    from_mem_o,
  output logic        busy_o
);

  localparam int cnt_width_lp = (latency_p > 0) ? $clog2(latency_p + 1) : 1;
  localparam int depth_lp     = 2 ** addr_width_p;

  typedef enum logic [1:0] {IDLE, ACK, WAIT, RESP} state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [cnt_width_lp-1:0] r_cnt;
  logic [cnt_width_lp-1:0] w_cnt_nxt;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [depth_lp];

  logic                    w_accept;
  logic [addr_width_p-1:0] w_idx;
  logic [4:0]              w_lane_sh;
  logic [31:0]             w_old;
  logic [7:0]              w_lane_byte;
  logic [31:0]             w_wr_word;
  logic [31:0]             w_rd_word;
  logic                    w_unused_addr;

  // Address bits above the array and, for word ops, the lane bits are don't-care.
  assign w_unused_addr = ^addr_i;

  // Reset gates acceptance so a request seen while reset is high never writes.
  assign w_accept    = (r_state == IDLE) && to_mem_i.valid && !reset;
  assign w_idx       = addr_i[addr_width_p+1:2];
  assign w_lane_sh   = {addr_i[1:0], 3'b000};
  assign w_old       = r_mem[w_idx];
  assign w_lane_byte = w_old[w_lane_sh +: 8];

  always_comb begin
    w_wr_word = to_mem_i.write_data;
    w_rd_word = w_old;
    if (to_mem_i.byte_not_word) begin
      w_wr_word                = w_old;
      w_wr_word[w_lane_sh +: 8] = to_mem_i.write_data[7:0];
      w_rd_word                = {24'b0, w_lane_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && to_mem_i.wen) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rdata <= to_mem_i.wen ? 32'b0 : w_rd_word;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (to_mem_i.valid) begin
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        if (latency_p == 0) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = cnt_width_lp'(latency_p);
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == cnt_width_lp'(1)) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (to_mem_i.yumi) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    from_mem_o.read_data = r_rdata;
    from_mem_o.valid     = (r_state == RESP);
    from_mem_o.yumi      = (r_state == ACK);
    busy_o               = (r_state != IDLE);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (latency 2 and latency 0) driven by directed and
// random requests; a word-array reference model feeds per-instance expected-response queues.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 1024;

  logic     clk = 1'b0;
  logic     rst      [2];
  mem_in_s  to_mem   [2];
  logic [31:0] addr  [2];
  mem_out_s from_mem [2];
  logic     busy     [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [2][DEPTH];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  always #5 clk = ~clk;

  dmem_responder #(.addr_width_p(10), .latency_p(2)) u_dut0 (
    .clk(clk), .reset(rst[0]), .to_mem_i(to_mem[0]), .addr_i(addr[0]),
    .from_mem_o(from_mem[0]), .busy_o(busy[0]));

  dmem_responder #(.addr_width_p(10), .latency_p(0)) u_dut1 (
    .clk(clk), .reset(rst[1]), .to_mem_i(to_mem[1]), .addr_i(addr[1]),
    .from_mem_o(from_mem[1]), .busy_o(busy[1]));

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d actual=0x%08h required=0x%08h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Reference model: a plain word array, little-endian byte lanes, addresses wrap by DEPTH.
  function automatic logic [31:0] mdl_access(input int d, input bit wen, input bit bnw,
                                             input logic [31:0] a, input logic [31:0] wd);
    int          idx;
    int          lane;
    logic [31:0] m;
    idx  = int'((a / 4) % DEPTH);
    lane = int'(a % 4);
    if (wen) begin
      if (bnw) begin
        m = 32'hFF << (8 * lane);
        mdl[d][idx] = (mdl[d][idx] & ~m) | ((wd & 32'hFF) << (8 * lane));
      end else begin
        mdl[d][idx] = wd;
      end
      return 32'h0;
    end
    if (bnw) return (mdl[d][idx] >> (8 * lane)) & 32'hFF;
    return mdl[d][idx];
  endfunction

  task automatic mon(input int d);
    logic [31:0] e;
    int          n;
    if (rst[d]) return;
    if (!from_mem[d].valid) return;
    chk("no_yumi_in_resp", d, 32'(from_mem[d].yumi), 32'h0);
    n = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_resp dut=%0d actual=0x%08h required=none", d, from_mem[d].read_data);
      return;
    end
    e = (d == 0) ? exp_q0[0] : exp_q1[0];
    chk("resp_data", d, from_mem[d].read_data, e);
    if (to_mem[d].yumi) begin
      if (d == 0) void'(exp_q0.pop_front());
      else        void'(exp_q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic do_req(input int d, input bit wen, input bit bnw, input logic [31:0] a,
                        input logic [31:0] wd, input int vhold, input int ydelay);
    int          lat;
    int          cyc;
    int          extra;
    logic [31:0] e;
    lat = (d == 0) ? 2 : 0;
    e = mdl_access(d, wen, bnw, a, wd);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    to_mem[d].valid         = 1'b1;
    to_mem[d].wen           = wen;
    to_mem[d].byte_not_word = bnw;
    to_mem[d].write_data    = wd;
    to_mem[d].yumi          = 1'b0;
    addr[d]                 = a;
    @(posedge clk); #1;
    chk("ack_yumi", d, 32'(from_mem[d].yumi), 32'h1);
    chk("ack_not_valid", d, 32'(from_mem[d].valid), 32'h0);
    chk("busy_in_ack", d, 32'(busy[d]), 32'h1);
    cyc   = 1;
    extra = 0;
    while (!from_mem[d].valid && cyc < lat + 12) begin
      to_mem[d].valid = (cyc < vhold);
      to_mem[d].yumi  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (from_mem[d].yumi) extra++;
    end
    to_mem[d].valid = 1'b0;
    to_mem[d].yumi  = 1'b0;
    chk("resp_latency", d, 32'(cyc - 1), 32'(lat + 1));
    for (int k = 0; k < ydelay; k++) begin
      @(posedge clk); #1;
      chk("resp_held", d, 32'(from_mem[d].valid), 32'h1);
      if (from_mem[d].yumi) extra++;
    end
    chk("single_ack", d, 32'(extra), 32'h0);
    to_mem[d].yumi = 1'b1;
    @(posedge clk); #1;
    to_mem[d].yumi = 1'b0;
    chk("idle_after_yumi", d, 32'(busy[d]), 32'h0);
    chk("valid_drops", d, 32'(from_mem[d].valid), 32'h0);
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_valid", d, 32'(from_mem[d].valid), 32'h0);
    chk("rst_yumi", d, 32'(from_mem[d].yumi), 32'h0);
    chk("rst_rdata", d, from_mem[d].read_data, 32'h0);
    chk("rst_busy", d, 32'(busy[d]), 32'h0);
  endtask

  // Reset lands in WAIT on the latency-2 instance; a store accepted before it still counts.
  task automatic abort_req(input int d, input bit wen, input bit bnw, input logic [31:0] a,
                           input logic [31:0] wd);
    void'(mdl_access(d, wen, bnw, a, wd));
    to_mem[d].valid         = 1'b1;
    to_mem[d].wen           = wen;
    to_mem[d].byte_not_word = bnw;
    to_mem[d].write_data    = wd;
    addr[d]                 = a;
    @(posedge clk); #1;
    to_mem[d].valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_before_rst", d, 32'(busy[d]), 32'h1);
    rst[d] = 1'b1;
    #1;
    chk_reset_outputs(d);
    @(posedge clk); #1;
    rst[d] = 1'b0;
  endtask

  task automatic write_under_reset(input int d, input logic [31:0] a, input logic [31:0] wd);
    rst[d]                  = 1'b1;
    to_mem[d].valid         = 1'b1;
    to_mem[d].wen           = 1'b1;
    to_mem[d].byte_not_word = 1'b0;
    to_mem[d].write_data    = wd;
    addr[d]                 = a;
    repeat (2) @(posedge clk);
    #1;
    to_mem[d].valid = 1'b0;
    chk_reset_outputs(d);
    rst[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a       = $urandom();
    a[11:2] = 10'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]    = 1'b1;
      to_mem[d] = '0;
      addr[d]   = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs(0);

    do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1, 0);
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 1, 0);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h11223344, 1, 0);
    do_req(0, 1'b1, 1'b1, 32'h11, 32'hFFFFFFAA, 1, 0);
    do_req(0, 1'b0, 1'b1, 32'h11, 32'h0, 1, 0);
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 1, 0);
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 2, 5);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h01020304, 1, 0);
    do_req(0, 1'b0, 1'b0, 32'h13, 32'h0, 1, 0);

    abort_req(0, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D);
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, 1, 0);
    abort_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
    write_under_reset(0, 32'h10, 32'h55555555);
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 1, 0);

    do_req(1, 1'b1, 1'b0, 32'h8, 32'hA5A55A5A, 1, 0);
    do_req(1, 1'b0, 1'b0, 32'(DEPTH * 4 + 8), 32'h0, 1, 0);
    do_req(1, 1'b0, 1'b0, 32'h8, 32'h0, 2, 3);

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        do_req(d, 1'b1, 1'b0, 32'(w * 4), $urandom(), 1, 0);
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        do_req(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
               $urandom_range(1, 2), $urandom_range(0, 4));
      end
    end

    chk("queue_drained", 0, 32'(exp_q0.size()), 32'h0);
    chk("queue_drained", 1, 32'(exp_q1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
